triangle_setup: RTL

Consumes 16-bit words from the serial-to-parallel front end and assembles four of them into one triangle: three packed vertices plus a colour word. It then runs a three-cycle setup pipeline that computes signed area, winding correction and bounding box, and presents the triangle to the rasterizer over a valid/ready handshake. It paces the front end by pulsing that block's restart input (`valid_data`) whenever it can take another word.

---
 rtl/triangle_setup_pkg.sv | 45 ++++
 rtl/triangle_setup_if.sv | 38 +++
 rtl/tri_setup_math.sv | 85 ++++++++
 rtl/triangle_setup.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/triangle_setup_pkg.sv
// Shared definitions for the triangle setup block.
// Holds the controller state encoding, the word/coordinate/area widths,
// the datapath stage-enable bit positions and small min/max helpers.
package triangle_setup_pkg;

    localparam int COORD_W       = 8;
    localparam int WORD_W        = 16;
    localparam int AREA_W        = 17;
    localparam int WORDS_PER_TRI = 4;

    // Vertex differences need one extra bit for the sign; products double that.
    localparam int DIFF_W = COORD_W + 1;
    localparam int PROD_W = 2 * DIFF_W;

    // Bit positions inside the datapath stage-enable vector.
    localparam int STG_DIFF = 0;
    localparam int STG_MUL  = 1;
    localparam int STG_FIN  = 2;
    localparam int STG_N    = 3;

    typedef enum logic [2:0] {
        COLLECT,
        S_DIFF,
        S_MUL,
        S_FIN,
        PRESENT
    } state_t;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/triangle_setup_if.sv
// Bus between the triangle setup block and its neighbours.
// Front-end side : sipo_done, sipo_word (towards the block), sipo_restart (back).
// Rasterizer side: tri_valid plus the triangle fields (from the block), tri_ready (back).
// Status         : drop_count.
// Modport slave is the triangle setup block; modport master is its environment.
interface triangle_setup_if;
    import triangle_setup_pkg::*;

    logic                sipo_done;
    logic [WORD_W-1:0]   sipo_word;
    logic                sipo_restart;

    logic                tri_valid;
    logic                tri_ready;
    logic [COORD_W-1:0]  tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2;
    logic [WORD_W-1:0]   tri_color;
    logic [AREA_W-1:0]   tri_area2;
    logic [COORD_W-1:0]  tri_xmin, tri_xmax, tri_ymin, tri_ymax;
    logic                tri_flipped;
    logic [7:0]          drop_count;

    modport slave (
        input  sipo_done, sipo_word, tri_ready,
        output sipo_restart, tri_valid,
               tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
               tri_color, tri_area2, tri_xmin, tri_xmax, tri_ymin, tri_ymax,
               tri_flipped, drop_count
    );

    modport master (
        output sipo_done, sipo_word, tri_ready,
        input  sipo_restart, tri_valid,
               tri_x0, tri_y0, tri_x1, tri_y1, tri_x2, tri_y2,
               tri_color, tri_area2, tri_xmin, tri_xmax, tri_ymin, tri_ymax,
               tri_flipped, drop_count
    );

endinterface

// File: rtl/tri_setup_math.sv
// Registered setup datapath: vertex differences, cross products, then
// signed area, winding flag and bounding box.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stage_en_i          one enable per stage (STG_DIFF, STG_MUL, STG_FIN)
//   x0_i..y2_i          unsigned vertex coordinates, as collected
//   area2_o             |2*area|, registered at the finalize stage
//   flip_o              signed area was negative (v1/v2 must be swapped)
//   zero_o              current p - q is zero; valid while in the finalize stage
//   xmin_o..ymax_o      bounding box, registered at the finalize stage
module tri_setup_math
    import triangle_setup_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STG_N-1:0]   stage_en_i,
    input  logic [COORD_W-1:0] x0_i,
    input  logic [COORD_W-1:0] y0_i,
    input  logic [COORD_W-1:0] x1_i,
    input  logic [COORD_W-1:0] y1_i,
    input  logic [COORD_W-1:0] x2_i,
    input  logic [COORD_W-1:0] y2_i,
    output logic [AREA_W-1:0]  area2_o,
    output logic               flip_o,
    output logic               zero_o,
    output logic [COORD_W-1:0] xmin_o,
    output logic [COORD_W-1:0] xmax_o,
    output logic [COORD_W-1:0] ymin_o,
    output logic [COORD_W-1:0] ymax_o
);

    logic signed [DIFF_W-1:0] dx1_q, dy1_q, dx2_q, dy2_q;
    logic signed [PROD_W-1:0] p_q, q_q;
    logic signed [PROD_W-1:0] dx1_w, dy1_w, dx2_w, dy2_w;
    logic signed [PROD_W-1:0] a_w;
    logic        [PROD_W-1:0] abs_a_w;

    // Explicit sign extension keeps the products at full width.
    assign dx1_w = $signed({{DIFF_W{dx1_q[DIFF_W-1]}}, dx1_q});
    assign dy1_w = $signed({{DIFF_W{dy1_q[DIFF_W-1]}}, dy1_q});
    assign dx2_w = $signed({{DIFF_W{dx2_q[DIFF_W-1]}}, dx2_q});
    assign dy2_w = $signed({{DIFF_W{dy2_q[DIFF_W-1]}}, dy2_q});

    // |p|,|q| <= 255*255, so p - q stays within 18-bit signed range.
    assign a_w     = p_q - q_q;
    assign abs_a_w = a_w[PROD_W-1] ? -a_w : a_w;
    assign zero_o  = (a_w == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            dx1_q   <= '0;
            dy1_q   <= '0;
            dx2_q   <= '0;
            dy2_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            area2_o <= '0;
            flip_o  <= 1'b0;
            xmin_o  <= '0;
            xmax_o  <= '0;
            ymin_o  <= '0;
            ymax_o  <= '0;
        end else begin
            if (stage_en_i[STG_DIFF]) begin
                dx1_q <= $signed({1'b0, x1_i}) - $signed({1'b0, x0_i});
                dy1_q <= $signed({1'b0, y1_i}) - $signed({1'b0, y0_i});
                dx2_q <= $signed({1'b0, x2_i}) - $signed({1'b0, x0_i});
                dy2_q <= $signed({1'b0, y2_i}) - $signed({1'b0, y0_i});
            end
            if (stage_en_i[STG_MUL]) begin
                p_q <= dx1_w * dy2_w;
                q_q <= dx2_w * dy1_w;
            end
            if (stage_en_i[STG_FIN]) begin
                area2_o <= AREA_W'(abs_a_w);
                flip_o  <= a_w[PROD_W-1];
                xmin_o  <= min3(x0_i, x1_i, x2_i);
                xmax_o  <= max3(x0_i, x1_i, x2_i);
                ymin_o  <= min3(y0_i, y1_i, y2_i);
                ymax_o  <= max3(y0_i, y1_i, y2_i);
            end
        end
    end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: collects four 16-bit words (v0, v1, v2, colour) from the
// serial-to-parallel front end, runs the three-stage setup datapath and
// presents the finished triangle to the rasterizer with valid/ready.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        triangle_setup_if.slave: front-end word/restart handshake,
//              rasterizer valid/ready plus triangle fields, drop counter
// Parameter DROP_DEGENERATE: 1 discards zero-area triangles, 0 emits them.
//
// state   | meaning
// COLLECT | waiting for words; widx selects the slot for the next word
// S_DIFF  | register vertex differences
// S_MUL   | register cross products
// S_FIN   | register area/flip/bbox; drop or go present
// PRESENT | tri_valid high, outputs frozen until tri_ready
module triangle_setup
    import triangle_setup_pkg::*;
#(
    parameter bit DROP_DEGENERATE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    triangle_setup_if.slave bus
);

    state_t            state_q, state_d;
    logic [1:0]        widx_q, widx_d;
    logic              restart_q, restart_d;
    logic [7:0]        drop_q, drop_d;
    logic              store_en;
    logic [STG_N-1:0]  stage_en;

    logic [WORD_W-1:0] v0_q, v1_q, v2_q, color_q;

    logic [AREA_W-1:0]  area2;
    logic               flip, area_zero;
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax;

    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        restart_d = 1'b0;
        drop_d    = drop_q;
        store_en  = 1'b0;
        stage_en  = '0;
        case (state_q)
            COLLECT: begin
                if (bus.sipo_done) begin
                    store_en = 1'b1;
                    if (widx_q != 2'(WORDS_PER_TRI - 1)) begin
                        widx_d    = widx_q + 2'd1;
                        restart_d = 1'b1;
                    end else begin
                        widx_d  = '0;
                        state_d = S_DIFF;
                    end
                end
            end
            S_DIFF: begin
                stage_en[STG_DIFF] = 1'b1;
                state_d            = S_MUL;
            end
            S_MUL: begin
                stage_en[STG_MUL] = 1'b1;
                state_d           = S_FIN;
            end
            S_FIN: begin
                stage_en[STG_FIN] = 1'b1;
                if (area_zero && DROP_DEGENERATE) begin
                    if (drop_q != 8'hFF) begin
                        drop_d = drop_q + 8'd1;
                    end
                    restart_d = 1'b1;
                    state_d   = COLLECT;
                end else begin
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.tri_ready) begin
                    restart_d = 1'b1;
                    state_d   = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COLLECT;
            widx_q    <= '0;
            restart_q <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            widx_q    <= widx_d;
            restart_q <= restart_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q    <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            color_q <= '0;
        end else if (store_en) begin
            case (widx_q)
                2'd0:    v0_q    <= bus.sipo_word;
                2'd1:    v1_q    <= bus.sipo_word;
                2'd2:    v2_q    <= bus.sipo_word;
                default: color_q <= bus.sipo_word;
            endcase
        end
    end

    tri_setup_math u_math (
        .clk        (clk),
        .rst        (rst),
        .stage_en_i (stage_en),
        .x0_i       (v0_q[WORD_W-1:COORD_W]),
        .y0_i       (v0_q[COORD_W-1:0]),
        .x1_i       (v1_q[WORD_W-1:COORD_W]),
        .y1_i       (v1_q[COORD_W-1:0]),
        .x2_i       (v2_q[WORD_W-1:COORD_W]),
        .y2_i       (v2_q[COORD_W-1:0]),
        .area2_o    (area2),
        .flip_o     (flip),
        .zero_o     (area_zero),
        .xmin_o     (xmin),
        .xmax_o     (xmax),
        .ymin_o     (ymin),
        .ymax_o     (ymax)
    );

    // Winding correction is applied on the way out; the slots keep arrival order.
    assign bus.tri_x0      = v0_q[WORD_W-1:COORD_W];
    assign bus.tri_y0      = v0_q[COORD_W-1:0];
    assign bus.tri_x1      = flip ? v2_q[WORD_W-1:COORD_W] : v1_q[WORD_W-1:COORD_W];
    assign bus.tri_y1      = flip ? v2_q[COORD_W-1:0]      : v1_q[COORD_W-1:0];
    assign bus.tri_x2      = flip ? v1_q[WORD_W-1:COORD_W] : v2_q[WORD_W-1:COORD_W];
    assign bus.tri_y2      = flip ? v1_q[COORD_W-1:0]      : v2_q[COORD_W-1:0];
    assign bus.tri_color   = color_q;
    assign bus.tri_area2   = area2;
    assign bus.tri_flipped = flip;
    assign bus.tri_xmin    = xmin;
    assign bus.tri_xmax    = xmax;
    assign bus.tri_ymin    = ymin;
    assign bus.tri_ymax    = ymax;

    assign bus.tri_valid    = (state_q == PRESENT);
    assign bus.sipo_restart = restart_q;
    assign bus.drop_count   = drop_q;

endmodule
